// File: rtl/centroid_pkg.sv
// centroid_pkg: shared types and default widths for the multi-channel centroid engine.
//   centroid_state_t  - snapshot-processing FSM states
//   centroid_result_t - one reported channel result (default widths)
//   ch_width()        - channel-tag width for a given channel count
package centroid_pkg;

    localparam int unsigned DEF_NUM_CH     = 4;
    localparam int unsigned DEF_X_WIDTH    = 11;
    localparam int unsigned DEF_Y_WIDTH    = 10;
    localparam int unsigned DEF_ACC_WIDTH  = 32;
    localparam int unsigned DEF_MIN_PIXELS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV_X,
        ST_DIV_Y,
        ST_EMIT
    } centroid_state_t;

    typedef struct packed {
        logic [DEF_X_WIDTH-1:0]   x;
        logic [DEF_Y_WIDTH-1:0]   y;
        logic [DEF_ACC_WIDTH-1:0] count;
        logic                     present;
    } centroid_result_t;

    // Channel tag width; a single channel still needs one tag bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/centroid_seq_divider.sv
// centroid_seq_divider: unsigned radix-2 restoring divider, one quotient bit per cycle.
//   clk_in, rst_in      - clock, asynchronous active-high reset
//   start_in            - capture operands and begin (first bit resolved on this edge)
//   dividend_in         - numerator
//   divisor_in          - denominator (non-zero)
//   done_out            - one-cycle pulse exactly WIDTH cycles after start_in
//   quotient_out        - floor(dividend/divisor), valid while done_out is high
module centroid_seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             done_out,
    output logic [WIDTH-1:0] quotient_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] src_rem, src_quo, src_dsr;
    logic [WIDTH:0]   shifted, diff;

    // One restoring step per cycle; on start the step works on the fresh operands
    // so that the last bit lands exactly WIDTH cycles later.
    always_comb begin
        src_rem = start_in ? '0 : rem_q;
        src_quo = start_in ? dividend_in : quo_q;
        src_dsr = start_in ? divisor_in : dsr_q;
        shifted = {src_rem, src_quo[WIDTH-1]};
        diff    = shifted - {1'b0, src_dsr};

        rem_d  = rem_q;
        quo_d  = quo_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;

        if (start_in || (cnt_q != '0)) begin
            dsr_d = src_dsr;
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {src_quo[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {src_quo[WIDTH-2:0], 1'b0};
            end
        end

        if (start_in) begin
            cnt_d = CNT_W'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done_out     = done_q;
    assign quotient_out = quo_q;

endmodule

// File: rtl/multi_centroid.sv
// multi_centroid: per-channel x/y centroid engine with snapshot-and-divide at frame end.
//   clk_in, rst_in        - clock, asynchronous active-high reset
//   x_in, y_in, ch_in     - pixel coordinate and channel tag
//   valid_in              - pixel belongs to channel ch_in
//   tabulate_in           - end-of-frame pulse
//   x_out, y_out          - floor centroid of the reported channel
//   ch_out, count_out     - reported channel and its pixel count
//   present_out           - count_out >= MIN_PIXELS
//   valid_out             - one-cycle result strobe
//   busy_out              - snapshot being processed
//   overrun_out           - one-cycle pulse: a frame was dropped
module multi_centroid
    import centroid_pkg::*;
#(
    parameter  int unsigned NUM_CH     = DEF_NUM_CH,
    parameter  int unsigned X_WIDTH    = DEF_X_WIDTH,
    parameter  int unsigned Y_WIDTH    = DEF_Y_WIDTH,
    parameter  int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter  int unsigned MIN_PIXELS = DEF_MIN_PIXELS,
    localparam int unsigned CH_W       = ch_width(NUM_CH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [X_WIDTH-1:0]   x_in,
    input  logic [Y_WIDTH-1:0]   y_in,
    input  logic [CH_W-1:0]      ch_in,
    input  logic                 valid_in,
    input  logic                 tabulate_in,
    output logic [X_WIDTH-1:0]   x_out,
    output logic [Y_WIDTH-1:0]   y_out,
    output logic [CH_W-1:0]      ch_out,
    output logic [ACC_WIDTH-1:0] count_out,
    output logic                 present_out,
    output logic                 valid_out,
    output logic                 busy_out,
    output logic                 overrun_out
);

    logic [ACC_WIDTH-1:0] live_x_q [NUM_CH];
    logic [ACC_WIDTH-1:0] live_y_q [NUM_CH];
    logic [ACC_WIDTH-1:0] live_n_q [NUM_CH];
    logic [ACC_WIDTH-1:0] live_x_d [NUM_CH];
    logic [ACC_WIDTH-1:0] live_y_d [NUM_CH];
    logic [ACC_WIDTH-1:0] live_n_d [NUM_CH];
    logic [ACC_WIDTH-1:0] snap_x_q [NUM_CH];
    logic [ACC_WIDTH-1:0] snap_y_q [NUM_CH];
    logic [ACC_WIDTH-1:0] snap_n_q [NUM_CH];
    logic [ACC_WIDTH-1:0] snap_x_d [NUM_CH];
    logic [ACC_WIDTH-1:0] snap_y_d [NUM_CH];
    logic [ACC_WIDTH-1:0] snap_n_d [NUM_CH];

    centroid_state_t      state_q, state_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [X_WIDTH-1:0]   xq_q, xq_d;
    logic [X_WIDTH-1:0]   x_q, x_d;
    logic [Y_WIDTH-1:0]   y_q, y_d;
    logic [CH_W-1:0]      cho_q, cho_d;
    logic [ACC_WIDTH-1:0] count_q, count_d;
    logic                 present_q, present_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;

    logic                 div_start_c;
    logic [ACC_WIDTH-1:0] div_dividend_c;
    logic                 div_done;
    logic [ACC_WIDTH-1:0] div_quo;

    // Quotient high bits are zero by construction (sums bounded by count * max coordinate).
    logic unused_quo;
    assign unused_quo = ^div_quo;

    // Live accumulation; a same-cycle pixel is folded in before the snapshot copy and clear.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            live_x_d[c] = live_x_q[c];
            live_y_d[c] = live_y_q[c];
            live_n_d[c] = live_n_q[c];
            if (valid_in && (ch_in == CH_W'(c))) begin
                live_x_d[c] = live_x_q[c] + ACC_WIDTH'(x_in);
                live_y_d[c] = live_y_q[c] + ACC_WIDTH'(y_in);
                live_n_d[c] = live_n_q[c] + ACC_WIDTH'(1);
            end
            snap_x_d[c] = snap_x_q[c];
            snap_y_d[c] = snap_y_q[c];
            snap_n_d[c] = snap_n_q[c];
            if (tabulate_in && (state_q == ST_IDLE)) begin
                snap_x_d[c] = live_x_d[c];
                snap_y_d[c] = live_y_d[c];
                snap_n_d[c] = live_n_d[c];
            end
            if (tabulate_in) begin
                live_x_d[c] = '0;
                live_y_d[c] = '0;
                live_n_d[c] = '0;
            end
        end
    end

    // Snapshot walk: per channel LOAD -> (DIV_X -> DIV_Y ->) EMIT.
    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        xq_d           = xq_q;
        x_d            = x_q;
        y_d            = y_q;
        cho_d          = cho_q;
        count_d        = count_q;
        present_d      = present_q;
        valid_d        = 1'b0;
        div_start_c    = 1'b0;
        div_dividend_c = snap_x_q[ch_q];

        case (state_q)
            ST_IDLE: begin
                if (tabulate_in) begin
                    state_d = ST_LOAD;
                    ch_d    = '0;
                end
            end
            ST_LOAD: begin
                if (snap_n_q[ch_q] >= ACC_WIDTH'(MIN_PIXELS)) begin
                    div_start_c = 1'b1;
                    state_d     = ST_DIV_X;
                end else begin
                    state_d   = ST_EMIT;
                    x_d       = '0;
                    y_d       = '0;
                    present_d = 1'b0;
                    count_d   = snap_n_q[ch_q];
                    cho_d     = ch_q;
                    valid_d   = 1'b1;
                end
            end
            ST_DIV_X: begin
                if (div_done) begin
                    xq_d           = div_quo[X_WIDTH-1:0];
                    div_start_c    = 1'b1;
                    div_dividend_c = snap_y_q[ch_q];
                    state_d        = ST_DIV_Y;
                end
            end
            ST_DIV_Y: begin
                if (div_done) begin
                    state_d   = ST_EMIT;
                    x_d       = xq_q;
                    y_d       = div_quo[Y_WIDTH-1:0];
                    present_d = 1'b1;
                    count_d   = snap_n_q[ch_q];
                    cho_d     = ch_q;
                    valid_d   = 1'b1;
                end
            end
            ST_EMIT: begin
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d    = (state_d != ST_IDLE);
        overrun_d = tabulate_in && (state_q != ST_IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
                live_x_q[c] <= '0;
                live_y_q[c] <= '0;
                live_n_q[c] <= '0;
                snap_x_q[c] <= '0;
                snap_y_q[c] <= '0;
                snap_n_q[c] <= '0;
            end
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            xq_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            cho_q     <= '0;
            count_q   <= '0;
            present_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                live_x_q[c] <= live_x_d[c];
                live_y_q[c] <= live_y_d[c];
                live_n_q[c] <= live_n_d[c];
                snap_x_q[c] <= snap_x_d[c];
                snap_y_q[c] <= snap_y_d[c];
                snap_n_q[c] <= snap_n_d[c];
            end
            state_q   <= state_d;
            ch_q      <= ch_d;
            xq_q      <= xq_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cho_q     <= cho_d;
            count_q   <= count_d;
            present_q <= present_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    centroid_seq_divider #(
        .WIDTH (ACC_WIDTH)
    ) u_div (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (div_start_c),
        .dividend_in  (div_dividend_c),
        .divisor_in   (snap_n_q[ch_q]),
        .done_out     (div_done),
        .quotient_out (div_quo)
    );

    assign x_out       = x_q;
    assign y_out       = y_q;
    assign ch_out      = cho_q;
    assign count_out   = count_q;
    assign present_out = present_q;
    assign valid_out   = valid_q;
    assign busy_out    = busy_q;
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_multi_centroid.sv
// tb_multi_centroid: directed and random frames against a frame-level reference model.
module tb_multi_centroid;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned X_W     = 11;
    localparam int unsigned Y_W     = 10;
    localparam int unsigned ACC     = 32;
    localparam int unsigned MIN_PIX = 3;
    localparam int unsigned CH_W    = 2;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic [X_W-1:0] x_in;
    logic [Y_W-1:0] y_in;
    logic [CH_W-1:0] ch_in;
    logic           valid_in;
    logic           tabulate_in;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic [CH_W-1:0] ch_out;
    logic [ACC-1:0] count_out;
    logic           present_out;
    logic           valid_out;
    logic           busy_out;
    logic           overrun_out;

    multi_centroid #(
        .NUM_CH     (NUM_CH),
        .X_WIDTH    (X_W),
        .Y_WIDTH    (Y_W),
        .ACC_WIDTH  (ACC),
        .MIN_PIXELS (MIN_PIX)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .ch_in       (ch_in),
        .valid_in    (valid_in),
        .tabulate_in (tabulate_in),
        .x_out       (x_out),
        .y_out       (y_out),
        .ch_out      (ch_out),
        .count_out   (count_out),
        .present_out (present_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out),
        .overrun_out (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc = cyc + 1;

    typedef struct {
        int     cyc;
        int     ch;
        longint x;
        longint y;
        longint cnt;
        bit     pres;
    } ev_t;

    ev_t    exp_q[$];
    int     ov_q[$];
    longint sx[NUM_CH];
    longint sy[NUM_CH];
    longint sn[NUM_CH];
    int     busy_lo = 1;
    int     busy_hi = 0;
    longint hold_x = 0, hold_y = 0, hold_ch = 0, hold_cnt = 0;
    bit     hold_pres = 0;
    int     errors = 0;
    int     checks = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, cyc, act, want);
        end
    endfunction

    // Frame accepted at cycle t: lay out every channel's result cycle from the timing rules.
    function automatic void schedule(input int t);
        int  l;
        ev_t e;
        l = t + 1;
        for (int c = 0; c < NUM_CH; c++) begin
            e.ch  = c;
            e.cnt = sn[c];
            if (sn[c] >= MIN_PIX) begin
                e.pres = 1;
                e.x    = sx[c] / sn[c];
                e.y    = sy[c] / sn[c];
                e.cyc  = l + 2 * ACC + 1;
            end else begin
                e.pres = 0;
                e.x    = 0;
                e.y    = 0;
                e.cyc  = l + 1;
            end
            exp_q.push_back(e);
            l = e.cyc + 1;
        end
        busy_lo = t + 1;
        busy_hi = l - 1;
    endfunction

    function automatic void clear_live();
        for (int c = 0; c < NUM_CH; c++) begin
            sx[c] = 0;
            sy[c] = 0;
            sn[c] = 0;
        end
    endfunction

    // Drive one cycle of inputs and advance the model with it.
    task automatic step(input bit v, input int c, input int x, input int y, input bit tab);
        valid_in    = v;
        ch_in       = CH_W'(c);
        x_in        = X_W'(x);
        y_in        = Y_W'(y);
        tabulate_in = tab;
        if (v && c < NUM_CH) begin
            sx[c] += x;
            sy[c] += y;
            sn[c] += 1;
        end
        if (tab) begin
            if (cyc >= busy_lo && cyc <= busy_hi) ov_q.push_back(cyc + 1);
            else schedule(cyc);
            clear_live();
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_until(input int t);
        while (cyc < t) step(0, 0, 0, 0, 0);
    endtask

    task automatic wait_idle();
        while (cyc <= busy_hi) step(0, 0, 0, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"}, x_out, 0);
        chk({tag, "_y"}, y_out, 0);
        chk({tag, "_ch"}, ch_out, 0);
        chk({tag, "_count"}, count_out, 0);
        chk({tag, "_present"}, present_out, 0);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_overrun"}, overrun_out, 0);
    endtask

    task automatic do_reset_mid();
        valid_in    = 0;
        tabulate_in = 0;
        #1 rst_in = 1'b1;
        #1;
        chk_all_zero("async_reset");
        exp_q.delete();
        ov_q.delete();
        clear_live();
        busy_lo   = 1;
        busy_hi   = 0;
        hold_x    = 0;
        hold_y    = 0;
        hold_ch   = 0;
        hold_cnt  = 0;
        hold_pres = 0;
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_in) begin
        ev_t  e;
        logic exp_ov;
        if (!rst_in) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e         = exp_q.pop_front();
                hold_x    = e.x;
                hold_y    = e.y;
                hold_ch   = e.ch;
                hold_cnt  = e.cnt;
                hold_pres = e.pres;
                chk("valid_out", valid_out, 1);
            end else begin
                chk("valid_out", valid_out, 0);
            end
            chk("x_out", x_out, hold_x);
            chk("y_out", y_out, hold_y);
            chk("ch_out", ch_out, hold_ch);
            chk("count_out", count_out, hold_cnt);
            chk("present_out", present_out, hold_pres);
            exp_ov = 1'b0;
            if (ov_q.size() > 0 && ov_q[0] == cyc) begin
                exp_ov = 1'b1;
                void'(ov_q.pop_front());
            end
            chk("overrun_out", overrun_out, exp_ov);
            chk("busy_out", busy_out, (cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    initial begin
        int t0, t1, t2, t3, t4, t5, t6;
        int dens, len;
        rst_in      = 1'b1;
        valid_in    = 0;
        tabulate_in = 0;
        x_in        = '0;
        y_in        = '0;
        ch_in       = '0;
        clear_live();
        repeat (2) @(posedge clk_in);
        #1;
        chk_all_zero("reset");
        rst_in = 1'b0;

        // Three ch0 pixels: centroid (12,22), result 66 cycles after tabulate.
        step(1, 0, 10, 20, 0);
        step(1, 0, 12, 22, 0);
        step(1, 0, 14, 24, 0);
        t0 = cyc;
        step(0, 0, 0, 0, 1);
        idle_until(t0 + 66);
        chk("c1_valid", valid_out, 1);
        chk("c1_x", x_out, 12);
        chk("c1_y", y_out, 22);
        chk("c1_count", count_out, 3);
        chk("c1_present", present_out, 1);
        wait_idle();

        // Channel 2 only, x=0..19, y=5.
        for (int i = 0; i < 20; i++) step(1, 2, i, 5, 0);
        t0 = cyc;
        step(0, 0, 0, 0, 1);
        idle_until(t0 + 2);
        chk("c2_ch0_valid", valid_out, 1);
        chk("c2_ch0_present", present_out, 0);
        chk("c2_ch0_count", count_out, 0);
        idle_until(t0 + 70);
        chk("c2_ch2_valid", valid_out, 1);
        chk("c2_ch2_ch", ch_out, 2);
        chk("c2_ch2_x", x_out, 9);
        chk("c2_ch2_y", y_out, 5);
        chk("c2_ch2_count", count_out, 20);
        // Next frame accumulates while channel 3 is still being reported.
        step(1, 1, 7, 3, 0);
        step(1, 1, 9, 5, 0);
        chk("c2_busy_last_emit", busy_out, 1);
        step(0, 0, 0, 0, 0);
        chk("c2_busy_fall", busy_out, 0);
        // Tabulate on the first idle cycle, with a pixel on the same cycle.
        t1 = cyc;
        step(1, 1, 11, 7, 1);
        idle_until(t1 + 68);
        chk("c3_valid", valid_out, 1);
        chk("c3_ch", ch_out, 1);
        chk("c3_count", count_out, 3);
        chk("c3_x", x_out, 9);
        chk("c3_y", y_out, 5);
        wait_idle();
        t2 = cyc;
        step(0, 0, 0, 0, 1);
        idle_until(t2 + 4);
        chk("c3_next_count", count_out, 0);
        wait_idle();

        // Overrun: second tabulate during processing drops that frame.
        step(1, 3, 100, 200, 0);
        step(1, 3, 102, 202, 0);
        step(1, 3, 104, 204, 0);
        step(1, 3, 106, 206, 0);
        t3 = cyc;
        step(0, 0, 0, 0, 1);
        repeat (5) step(1, 3, 2000, 1000, 0);
        step(1, 3, 2000, 1000, 1);
        chk("ov_pulse", overrun_out, 1);
        step(0, 0, 0, 0, 0);
        chk("ov_single", overrun_out, 0);
        step(1, 0, 50, 60, 0);
        step(1, 0, 52, 62, 0);
        step(1, 0, 54, 64, 0);
        idle_until(t3 + 72);
        chk("ov_ch3_x", x_out, 103);
        chk("ov_ch3_y", y_out, 203);
        chk("ov_ch3_count", count_out, 4);
        wait_idle();
        t4 = cyc;
        step(0, 0, 0, 0, 1);
        idle_until(t4 + 66);
        chk("acc_ch0_x", x_out, 52);
        chk("acc_ch0_y", y_out, 62);
        chk("acc_ch0_count", count_out, 3);
        wait_idle();

        // Reset in the middle of the y division, then a normal frame.
        step(1, 0, 1, 1, 0);
        step(1, 0, 2, 2, 0);
        step(1, 0, 3, 3, 0);
        t5 = cyc;
        step(0, 0, 0, 0, 1);
        idle_until(t5 + 50);
        do_reset_mid();
        repeat (3) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 2, 30 + i, 40 + i, 0);
        t6 = cyc;
        step(0, 0, 0, 0, 1);
        idle_until(t6 + 70);
        chk("post_rst_valid", valid_out, 1);
        chk("post_rst_x", x_out, 31);
        chk("post_rst_y", y_out, 41);
        chk("post_rst_count", count_out, 4);
        wait_idle();

        // Random frames; short frames land tabulates inside processing.
        for (int f = 0; f < 12; f++) begin
            dens = ($urandom_range(0, 3) == 0) ? 2 : 50;
            len  = $urandom_range(20, 350);
            for (int k = 0; k < len; k++) begin
                step($urandom_range(0, 99) < dens, $urandom_range(0, NUM_CH - 1),
                     $urandom_range(0, 2047), $urandom_range(0, 1023), k == len - 1);
            end
        end
        wait_idle();
        repeat (5) step(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
